// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
package voice_alloc_pkg;

    localparam int unsigned NoteBw            = 8;
    localparam int unsigned VoiceNumDefault   = 4;
    localparam int unsigned VoiceAgeBwDefault = 4;

    // Allocator FSM: accept an event, scan every voice, then apply the decision.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StScan   = 2'd1,
        StCommit = 2'd2
    } va_state_e;

    // MIDI note numbers are 7-bit; a set MSB marks an event to be discarded.
    function automatic logic note_is_valid(input logic [NoteBw-1:0] note);
        return ~note[NoteBw-1];
    endfunction

endpackage

// File: rtl/voice_slot.sv
// One oscillator voice: active flag, current note and saturating age counter.
module voice_slot
    import voice_alloc_pkg::*;
#(
    parameter int unsigned AGE_BW = VoiceAgeBwDefault
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              load_i,     // start playing note_i
    input  logic [NoteBw-1:0] note_i,
    input  logic              release_i,  // stop playing, keep the note value
    input  logic              touch_i,    // clear age only
    input  logic              age_inc_i,  // age by one if active
    input  logic              clear_i,    // panic release
    output logic              active_o,
    output logic [NoteBw-1:0] note_o,
    output logic [AGE_BW-1:0] age_o
);

    localparam logic [AGE_BW-1:0] AgeMax = '1;

    logic              active_q, active_d;
    logic [NoteBw-1:0] note_q, note_d;
    logic [AGE_BW-1:0] age_q, age_d;

    // Next-state: panic clear wins, then load, release, touch, ageing.
    always_comb begin
        active_d = active_q;
        note_d   = note_q;
        age_d    = age_q;
        if (clear_i) begin
            active_d = 1'b0;
            age_d    = '0;
        end else if (load_i) begin
            active_d = 1'b1;
            note_d   = note_i;
            age_d    = '0;
        end else if (release_i) begin
            active_d = 1'b0;
            age_d    = '0;
        end else if (touch_i) begin
            age_d = '0;
        end else if (age_inc_i && active_q && (age_q != AgeMax)) begin
            age_d = age_q + 1'b1;
        end
    end

    // Voice state registers.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            active_q <= 1'b0;
            note_q   <= '0;
            age_q    <= '0;
        end else begin
            active_q <= active_d;
            note_q   <= note_d;
            age_q    <= age_d;
        end
    end

    assign active_o = active_q;
    assign note_o   = note_q;
    assign age_o    = age_q;

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: accepts note events, scans voices one per cycle, then
// retriggers, allocates a free voice or steals the oldest one.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = VoiceNumDefault,
    parameter int unsigned AGE_BW     = VoiceAgeBwDefault
) (
    input  logic                       clk_i,
    input  logic                       nrst_i,
    input  logic                       evValid_i,
    output logic                       evReady_o,
    input  logic                       evNoteOn_i,
    input  logic [NoteBw-1:0]          evNote_i,
    input  logic                       allOff_i,
    output logic [NUM_VOICES-1:0]      voiceEnable_o,
    output logic [NoteBw*NUM_VOICES-1:0] voiceNote_o,
    output logic                       stolen_o
);

    localparam int unsigned         IdxBw   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IdxBw-1:0]    LastIdx = IdxBw'(NUM_VOICES - 1);

    va_state_e         state_q, state_d;
    logic [IdxBw-1:0]  idx_q, idx_d;
    logic              ev_on_q, ev_on_d;
    logic [NoteBw-1:0] ev_note_q, ev_note_d;
    logic              match_found_q, match_found_d;
    logic [IdxBw-1:0]  match_idx_q, match_idx_d;
    logic              free_found_q, free_found_d;
    logic [IdxBw-1:0]  free_idx_q, free_idx_d;
    logic              old_found_q, old_found_d;
    logic [IdxBw-1:0]  old_idx_q, old_idx_d;
    logic [AGE_BW-1:0] old_age_q, old_age_d;
    logic              stolen_q, stolen_d;

    logic [NUM_VOICES-1:0] slot_active;
    logic [NoteBw-1:0]     slot_note [NUM_VOICES];
    logic [AGE_BW-1:0]     slot_age  [NUM_VOICES];

    logic [NUM_VOICES-1:0] slot_load, slot_release, slot_touch, slot_age_inc;
    logic                  slot_clear;

    logic              cur_active;
    logic [NoteBw-1:0] cur_note;
    logic [AGE_BW-1:0] cur_age;
    logic [IdxBw-1:0]  target;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot #(
            .AGE_BW(AGE_BW)
        ) u_slot (
            .clk_i    (clk_i),
            .nrst_i   (nrst_i),
            .load_i   (slot_load[g]),
            .note_i   (ev_note_q),
            .release_i(slot_release[g]),
            .touch_i  (slot_touch[g]),
            .age_inc_i(slot_age_inc[g]),
            .clear_i  (slot_clear),
            .active_o (slot_active[g]),
            .note_o   (slot_note[g]),
            .age_o    (slot_age[g])
        );
        assign voiceNote_o[g*NoteBw +: NoteBw] = slot_note[g];
    end

    // Select the voice currently under examination by the scan.
    always_comb begin
        cur_active = 1'b0;
        cur_note   = '0;
        cur_age    = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (IdxBw'(k) == idx_q) begin
                cur_active = slot_active[k];
                cur_note   = slot_note[k];
                cur_age    = slot_age[k];
            end
        end
    end

    // FSM next-state, candidate tracking and commit decision.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_found_d   = old_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        stolen_d      = 1'b0;
        slot_load     = '0;
        slot_release  = '0;
        slot_touch    = '0;
        slot_age_inc  = '0;
        slot_clear    = 1'b0;
        target        = free_found_q ? free_idx_q : old_idx_q;

        unique case (state_q)
            StIdle: begin
                if (evValid_i) begin
                    ev_on_d       = evNoteOn_i;
                    ev_note_d     = evNote_i;
                    idx_d         = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    old_found_d   = 1'b0;
                    match_idx_d   = '0;
                    free_idx_d    = '0;
                    old_idx_d     = '0;
                    old_age_d     = '0;
                    state_d       = StScan;
                end
            end
            StScan: begin
                if (cur_active && (cur_note == ev_note_q) && !match_found_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                if (!cur_active && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                // Strict compare keeps the lowest index on equal ages.
                if (cur_active && (!old_found_q || (cur_age > old_age_q))) begin
                    old_found_d = 1'b1;
                    old_idx_d   = idx_q;
                    old_age_d   = cur_age;
                end
                if (idx_q == LastIdx) begin
                    state_d = StCommit;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (note_is_valid(ev_note_q)) begin
                    for (int k = 0; k < NUM_VOICES; k++) begin
                        if (ev_on_q) begin
                            if (match_found_q) begin
                                slot_touch[k] = (IdxBw'(k) == match_idx_q);
                            end else if (IdxBw'(k) == target) begin
                                slot_load[k] = 1'b1;
                            end else begin
                                slot_age_inc[k] = 1'b1;
                            end
                        end else if (match_found_q) begin
                            slot_release[k] = (IdxBw'(k) == match_idx_q);
                        end
                    end
                    stolen_d = ev_on_q && !match_found_q && !free_found_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Panic overrides everything, including an event handshaking this cycle.
        if (allOff_i) begin
            state_d    = StIdle;
            stolen_d   = 1'b0;
            slot_clear = 1'b1;
        end
    end

    // Allocator state registers.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_found_q   <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            stolen_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_found_q   <= old_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            stolen_q      <= stolen_d;
        end
    end

    assign evReady_o     = (state_q == StIdle);
    assign voiceEnable_o = slot_active;
    assign stolen_o      = stolen_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Randomized self-checking bench for voice_alloc against a behavioural voice model.
module tb_voice_alloc;

    localparam int N      = 4;
    localparam int AgeMax = 15;

    logic           clk = 1'b0;
    logic           nrst;
    logic           evValid, evReady, evNoteOn, allOff, stolen;
    logic [7:0]     evNote;
    logic [N-1:0]   voiceEnable;
    logic [8*N-1:0] voiceNote;

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-voice playing flag, last note and age.
    int m_act  [N];
    int m_note [N];
    int m_age  [N];

    voice_alloc #(
        .NUM_VOICES(N),
        .AGE_BW    (4)
    ) dut (
        .clk_i        (clk),
        .nrst_i       (nrst),
        .evValid_i    (evValid),
        .evReady_o    (evReady),
        .evNoteOn_i   (evNoteOn),
        .evNote_i     (evNote),
        .allOff_i     (allOff),
        .voiceEnable_o(voiceEnable),
        .voiceNote_o  (voiceNote),
        .stolen_o     (stolen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_act[k] = 0; m_note[k] = 0; m_age[k] = 0;
        end
    endfunction

    function automatic void model_alloff();
        for (int k = 0; k < N; k++) begin
            m_act[k] = 0; m_age[k] = 0;
        end
    endfunction

    // Applies one event; returns 1 when a playing voice was stolen.
    function automatic bit model_event(input bit on, input int n);
        int hit = -1;
        int fr  = -1;
        int old = -1;
        int tgt;
        if (n > 127) return 1'b0;
        for (int k = 0; k < N; k++) begin
            if (hit < 0 && m_act[k] != 0 && m_note[k] == n) hit = k;
            if (fr < 0 && m_act[k] == 0) fr = k;
            if (m_act[k] != 0 && (old < 0 || m_age[k] > m_age[old])) old = k;
        end
        if (!on) begin
            if (hit >= 0) begin
                m_act[hit] = 0; m_age[hit] = 0;
            end
            return 1'b0;
        end
        if (hit >= 0) begin
            m_age[hit] = 0;
            return 1'b0;
        end
        tgt = (fr >= 0) ? fr : old;
        for (int k = 0; k < N; k++) begin
            if (k != tgt && m_act[k] != 0 && m_age[k] < AgeMax) m_age[k]++;
        end
        m_act[tgt] = 1; m_note[tgt] = n; m_age[tgt] = 0;
        return (fr < 0);
    endfunction

    function automatic logic [N-1:0] exp_en();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = (m_act[k] != 0);
        return v;
    endfunction

    function automatic logic [8*N-1:0] exp_notes();
        logic [8*N-1:0] v;
        for (int k = 0; k < N; k++) v[8*k +: 8] = 8'(m_note[k]);
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".en"}, 64'(voiceEnable), 64'(exp_en()));
        check_eq({tag, ".notes"}, 64'(voiceNote), 64'(exp_notes()));
    endtask

    // Called at a negedge; returns at the negedge after the commit edge.
    task automatic do_event(input bit on, input logic [7:0] n);
        int w = 0;
        bit exp_steal;
        while (!evReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!evReady) check_eq("ready_timeout", 64'(evReady), 64'd1);
        evValid = 1'b1; evNoteOn = on; evNote = n;
        @(posedge clk);
        exp_steal = model_event(on, int'(n));
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge clk);
            check_eq("busy_ready", 64'(evReady), 64'd0);
            check_eq("busy_stolen", 64'(stolen), 64'd0);
            // Junk on the input while busy must be ignored.
            evValid  = 1'($urandom);
            evNoteOn = 1'($urandom);
            evNote   = 8'($urandom);
        end
        @(negedge clk);
        evValid = 1'b0;
        check_eq("ready_back", 64'(evReady), 64'd1);
        check_eq("stolen", 64'(stolen), 64'(exp_steal));
        check_outputs("commit");
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic pulse_alloff();
        @(negedge clk);
        allOff = 1'b1;
        @(posedge clk);
        model_alloff();
        @(negedge clk);
        allOff = 1'b0;
        check_eq("alloff_ready", 64'(evReady), 64'd1);
        check_outputs("alloff");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; evValid = 1'b0; evNoteOn = 1'b0; evNote = 8'd0; allOff = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Reset state.
        check_eq("rst.en", 64'(voiceEnable), 64'd0);
        check_eq("rst.notes", 64'(voiceNote), 64'd0);
        check_eq("rst.stolen", 64'(stolen), 64'd0);
        check_eq("rst.ready", 64'(evReady), 64'd1);

        // First note lands on voice 0.
        do_event(1'b1, 8'd60);
        check_eq("t1.en", 64'(voiceEnable), 64'h1);
        check_eq("t1.v0", 64'(voiceNote[7:0]), 64'd60);

        // Fill all voices, then steal the oldest (voice 0).
        do_reset();
        do_event(1'b1, 8'd60);
        do_event(1'b1, 8'd62);
        do_event(1'b1, 8'd64);
        do_event(1'b1, 8'd65);
        do_event(1'b1, 8'd67);
        check_eq("t2.stolen", 64'(stolen), 64'd1);
        check_eq("t2.notes", 64'(voiceNote), 64'h4140_3E43);
        @(negedge clk);
        check_eq("t2.pulse_once", 64'(stolen), 64'd0);

        // Note-off frees voice 1, which is reused first.
        do_reset();
        do_event(1'b1, 8'd60);
        do_event(1'b1, 8'd62);
        do_event(1'b0, 8'd62);
        check_eq("t3.en_off", 64'(voiceEnable), 64'h1);
        do_event(1'b1, 8'd70);
        check_eq("t3.en", 64'(voiceEnable), 64'h3);
        check_eq("t3.v1", 64'(voiceNote[15:8]), 64'd70);

        // Retrigger keeps a single voice.
        do_reset();
        do_event(1'b1, 8'd60);
        do_event(1'b1, 8'd60);
        check_eq("t4.en", 64'(voiceEnable), 64'h1);

        // Unmatched note-off and invalid note do nothing.
        do_reset();
        do_event(1'b0, 8'd50);
        do_event(1'b1, 8'd200);
        check_eq("t5.en", 64'(voiceEnable), 64'h0);
        check_eq("t5.notes", 64'(voiceNote), 64'h0);

        // Panic during SCAN drops the in-flight note-on.
        do_reset();
        do_event(1'b1, 8'd60);
        evValid = 1'b1; evNoteOn = 1'b1; evNote = 8'd62;
        @(posedge clk);
        @(negedge clk);
        evValid = 1'b0;
        allOff  = 1'b1;
        @(posedge clk);
        model_alloff();
        @(negedge clk);
        allOff = 1'b0;
        check_eq("t6.en", 64'(voiceEnable), 64'h0);
        check_eq("t6.ready", 64'(evReady), 64'd1);
        repeat (N + 2) @(negedge clk);
        check_outputs("t6.after");

        // Panic wins over a same-cycle handshake.
        evValid = 1'b1; evNoteOn = 1'b1; evNote = 8'd66; allOff = 1'b1;
        @(negedge clk);
        evValid = 1'b0; allOff = 1'b0;
        check_eq("t7.ready", 64'(evReady), 64'd1);
        repeat (N + 2) @(negedge clk);
        check_outputs("t7.after");

        // Reset during COMMIT: no partial commit.
        do_reset();
        do_event(1'b1, 8'd60);
        do_event(1'b1, 8'd62);
        evValid = 1'b1; evNoteOn = 1'b1; evNote = 8'd64;
        @(posedge clk);
        for (int c = 0; c < N + 1; c++) @(negedge clk);
        evValid = 1'b0;
        nrst = 1'b0;
        #1;
        model_reset();
        check_eq("t8.en", 64'(voiceEnable), 64'h0);
        check_eq("t8.notes", 64'(voiceNote), 64'h0);
        check_eq("t8.stolen", 64'(stolen), 64'd0);
        check_eq("t8.ready", 64'(evReady), 64'd1);
        @(negedge clk);
        nrst = 1'b1;

        // Randomized traffic over a narrow note range to force matches and steals.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [7:0] n;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                pulse_alloff();
            end else begin
                n = (r < 12) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(56, 66));
                do_event($urandom_range(0, 99) < 60, n);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
